// File: rtl/ysyx_24090013_rf_pkg.sv
// Shared constants, address type and the write/read hit helper for the NPC register file.
package ysyx_24090013_rf_pkg;

    localparam int unsigned REG_X0   = 0;
    localparam int unsigned REG_A0   = 10;
    localparam int unsigned RF_AW    = 5;
    localparam int unsigned RF_CMP_W = 16;

    typedef logic [RF_AW-1:0]    rf_addr_t;
    typedef logic [RF_CMP_W-1:0] rf_cmp_t;

    // Callers widen their addresses to rf_cmp_t, so any AW up to 16 bits shares this helper.
    function automatic logic rf_hit(input logic en, input rf_cmp_t a, input rf_cmp_t b);
        return en && (a == b) && (a != rf_cmp_t'(REG_X0));
    endfunction

endpackage

// File: rtl/ysyx_24090013_rf_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, a same-cycle set wins; bit 0 is never set.
module ysyx_24090013_rf_scoreboard
    import ysyx_24090013_rf_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    output logic [(1<<AW)-1:0] busy_vec
);

    localparam int unsigned NREG = 1 << AW;

    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] busy_q;

    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 0; r < NREG; r++) begin
            if (rf_hit(set_en, rf_cmp_t'(set_addr), rf_cmp_t'(r))) begin
                busy_d[r] = 1'b1;
            end else if (rf_hit(clr_en, rf_cmp_t'(clr_addr), rf_cmp_t'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/ysyx_24090013_regfile_sb.sv
// NR_RD-read / 1-write GPR file with busy scoreboard for RAW/WAW stalls.
// Define YSYX_24090013_RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module ysyx_24090013_regfile_sb
    import ysyx_24090013_rf_pkg::*;
#(
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32,
    parameter int unsigned NR_RD = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wen,
    input  logic [AW-1:0]         waddr,
    input  logic [DW-1:0]         wdata,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    output logic                  iss_ready,
    input  logic [NR_RD-1:0]      rd_ren,
    input  logic [NR_RD*AW-1:0]   rd_addr,
    output logic [NR_RD*DW-1:0]   rd_data,
    output logic [NR_RD-1:0]      rd_busy,
    output logic [(1<<AW)-1:0]    busy_vec
);

    localparam int unsigned NREG = 1 << AW;

    logic [DW-1:0] rf_d [NREG];
    logic [DW-1:0] rf_q [NREG];
    logic          wr_fire;
    logic          set_en;
    logic [AW-1:0] rd_a;

    assign wr_fire = rf_hit(wen, rf_cmp_t'(waddr), rf_cmp_t'(waddr));

    // A writeback to iss_rd in this cycle frees the slot, so the new owner may issue.
    assign iss_ready = !((iss_rd != '0) && busy_vec[iss_rd]
                         && !rf_hit(wen, rf_cmp_t'(waddr), rf_cmp_t'(iss_rd)));
    assign set_en    = iss_valid && iss_ready && (iss_rd != '0);

    ysyx_24090013_rf_scoreboard #(
        .AW (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (set_en),
        .set_addr (iss_rd),
        .clr_en   (wr_fire),
        .clr_addr (waddr),
        .busy_vec (busy_vec)
    );

    always_comb begin
        rf_d = rf_q;
        if (wr_fire) begin
            rf_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                rf_q[r] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_a    = '0;
        for (int unsigned i = 0; i < NR_RD; i++) begin
            rd_a = rd_addr[i*AW +: AW];
            if (rd_ren[i] && (rd_a != '0)) begin
                rd_data[i*DW +: DW] = rf_q[rd_a];
                rd_busy[i]          = busy_vec[rd_a];
`ifdef YSYX_24090013_RF_BYPASS_EN
                if (rf_hit(wen, rf_cmp_t'(waddr), rf_cmp_t'(rd_a))) begin
                    rd_data[i*DW +: DW] = wdata;
                    rd_busy[i]          = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24090013_regfile_sb.sv
// Directed bench: stimulus pushes expected values to a queue, a negedge monitor pops and compares.
module tb_ysyx_24090013_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [1:0]  rd_ren;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [31:0] busy_vec;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    typedef struct {
        string       name;
        int unsigned sel;
        logic [31:0] exp;
    } chk_t;

    chk_t exp_q[$];

    localparam int unsigned S_RD0 = 0, S_RD1 = 1, S_BUSY0 = 2, S_BUSY1 = 3, S_ISSRDY = 4, S_BVEC = 5;

    ysyx_24090013_regfile_sb #(
        .AW    (5),
        .DW    (32),
        .NR_RD (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .rd_ren    (rd_ren),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .busy_vec  (busy_vec)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int unsigned sel);
        case (sel)
            S_RD0:    return rd_data[31:0];
            S_RD1:    return rd_data[63:32];
            S_BUSY0:  return {31'd0, rd_busy[0]};
            S_BUSY1:  return {31'd0, rd_busy[1]};
            S_ISSRDY: return {31'd0, iss_ready};
            default:  return busy_vec;
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            chk_t c;
            logic [31:0] act;
            c   = exp_q.pop_front();
            act = actual(c.sel);
            n_total++;
            if (act !== c.exp) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h at %0t", c.name, act, c.exp, $time);
            end
        end
    end

    task automatic expect_v(input string name, input int unsigned sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        exp_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic en0, input logic [4:0] a0, input logic en1, input logic [4:0] a1);
        rd_ren  = {en1, en0};
        rd_addr = {a1, a0};
    endtask

    task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d);
        wen   = en;
        waddr = a;
        wdata = d;
    endtask

    task automatic iss(input logic v, input logic [4:0] r);
        iss_valid = v;
        iss_rd    = r;
    endtask

    initial begin
        rst_n = 1'b0;
        wr(1'b0, 5'd0, 32'd0);
        iss(1'b0, 5'd0);
        rd(1'b0, 5'd0, 1'b0, 5'd0);
        expect_v("reset_busy_vec", S_BVEC, 32'd0);
        expect_v("reset_iss_ready", S_ISSRDY, 32'd1);
        #12 rst_n = 1'b1;
        tick();

        // 1: every register reads zero and idle on both ports
        for (int r = 0; r < 32; r++) begin
            rd(1'b1, 5'(r), 1'b1, 5'(r));
            expect_v("t1_rd0", S_RD0, 32'd0);
            expect_v("t1_rd1", S_RD1, 32'd0);
            expect_v("t1_busy0", S_BUSY0, 32'd0);
            expect_v("t1_busy1", S_BUSY1, 32'd0);
            tick();
        end

        // 2: x0 write discarded, x5 write lands
        rd(1'b0, 5'd0, 1'b0, 5'd0);
        wr(1'b1, 5'd0, 32'hDEADBEEF);
        tick();
        wr(1'b0, 5'd0, 32'd0);
        rd(1'b1, 5'd0, 1'b0, 5'd0);
        expect_v("t2_x0_zero", S_RD0, 32'd0);
        tick();
        wr(1'b1, 5'd5, 32'h1234);
        tick();
        wr(1'b0, 5'd0, 32'd0);
        rd(1'b1, 5'd5, 1'b0, 5'd0);
        expect_v("t2_x5_data", S_RD0, 32'h1234);
        expect_v("t2_x5_busy", S_BUSY0, 32'd0);
        tick();

        // 3: WAW stall on x7 released by writeback
        iss(1'b1, 5'd7);
        expect_v("t3_first_issue_ready", S_ISSRDY, 32'd1);
        tick();
        rd(1'b1, 5'd7, 1'b0, 5'd0);
        expect_v("t3_x7_busy", S_BUSY0, 32'd1);
        expect_v("t3_second_issue_blocked", S_ISSRDY, 32'd0);
        expect_v("t3_busy_vec", S_BVEC, 32'h0000_0080);
        tick();
        iss(1'b0, 5'd7);
        wr(1'b1, 5'd7, 32'hA5);
        expect_v("t3_ready_on_wb", S_ISSRDY, 32'd1);
        tick();
        wr(1'b0, 5'd0, 32'd0);
        expect_v("t3_busy_cleared", S_BVEC, 32'd0);
        expect_v("t3_x7_data", S_RD0, 32'hA5);
        expect_v("t3_x7_idle", S_BUSY0, 32'd0);
        iss(1'b1, 5'd7);
        tick();
        wr(1'b1, 5'd7, 32'hB6);
        expect_v("t3_reissue_ready", S_ISSRDY, 32'd1);
        tick();
        wr(1'b0, 5'd0, 32'd0);
        iss(1'b0, 5'd0);
        expect_v("t3_reissue_keeps_busy", S_BVEC, 32'h0000_0080);
        expect_v("t3_x7_new_data", S_RD0, 32'hB6);
        tick();
        wr(1'b1, 5'd7, 32'hB6);
        tick();
        wr(1'b0, 5'd0, 32'd0);
        expect_v("t3_final_clear", S_BVEC, 32'd0);
        tick();

        // 4: same-cycle writeback and issue on x9, new owner keeps busy
        iss(1'b1, 5'd9);
        tick();
        expect_v("t4_x9_busy", S_BVEC, 32'h0000_0200);
        wr(1'b1, 5'd9, 32'h55);
        expect_v("t4_ready_with_wb", S_ISSRDY, 32'd1);
        tick();
        wr(1'b0, 5'd0, 32'd0);
        iss(1'b0, 5'd0);
        rd(1'b1, 5'd9, 1'b0, 5'd0);
        expect_v("t4_x9_data", S_RD0, 32'h55);
        expect_v("t4_x9_still_busy", S_BUSY0, 32'd1);
        expect_v("t4_busy_vec", S_BVEC, 32'h0000_0200);
        tick();
        wr(1'b1, 5'd9, 32'h55);
        tick();
        wr(1'b0, 5'd0, 32'd0);

        // 5: same-cycle write/read of busy x3 on port 1
        wr(1'b1, 5'd3, 32'h11);
        iss(1'b1, 5'd3);
        tick();
        iss(1'b0, 5'd0);
        wr(1'b1, 5'd3, 32'hCAFE);
        rd(1'b0, 5'd5, 1'b1, 5'd3);
        expect_v("t5_ren_off_zero", S_RD0, 32'd0);
`ifdef YSYX_24090013_RF_BYPASS_EN
        expect_v("t5_bypass_data", S_RD1, 32'hCAFE);
        expect_v("t5_bypass_busy", S_BUSY1, 32'd0);
`else
        expect_v("t5_old_data", S_RD1, 32'h11);
        expect_v("t5_old_busy", S_BUSY1, 32'd1);
`endif
        tick();
        wr(1'b0, 5'd0, 32'd0);
        expect_v("t5_x3_after", S_RD1, 32'hCAFE);
        expect_v("t5_x3_idle", S_BUSY1, 32'd0);
        tick();
        rd(1'b1, 5'd5, 1'b1, 5'd5);
        expect_v("t5_same_addr_p0", S_RD0, 32'h1234);
        expect_v("t5_same_addr_p1", S_RD1, 32'h1234);
        tick();

        // 6: async reset mid-operation
        iss(1'b1, 5'd4);
        tick();
        iss(1'b1, 5'd6);
        tick();
        iss(1'b0, 5'd4);
        expect_v("t6_pending", S_BVEC, 32'h0000_0050);
        expect_v("t6_x4_blocked", S_ISSRDY, 32'd0);
        tick();
        rst_n = 1'b0;
        expect_v("t6_busy_dropped", S_BVEC, 32'd0);
        expect_v("t6_rf_cleared", S_RD0, 32'd0);
        expect_v("t6_ready", S_ISSRDY, 32'd1);
        tick();
        rst_n = 1'b1;
        wr(1'b1, 5'd4, 32'h77);
        tick();
        wr(1'b0, 5'd0, 32'd0);
        rd(1'b1, 5'd4, 1'b1, 5'd5);
        expect_v("t6_late_wb_data", S_RD0, 32'h77);
        expect_v("t6_late_wb_idle", S_BUSY0, 32'd0);
        expect_v("t6_x5_reset", S_RD1, 32'd0);
        expect_v("t6_busy_vec_zero", S_BVEC, 32'd0);
        tick();
        tick();

        if (exp_q.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
